// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - clear/load/shift sequencer for the 4-bit universal shift register
//
// Walks the datapath through one complete operation per accepted start:
// CLR (dp_reset pulse), LOAD (s1s0=11), SHIFT for `count` cycles (s1s0=latched op),
// then DONE (one-cycle done pulse). Every output is a flop; next-output values
// are decoded from the next state, so no input reaches an output combinationally.
//
// Select encoding (s1,s0): 00 hold, 01 shift right, 10 shift left, 11 parallel load.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   request an operation (accepted only in IDLE)
//   op        in   [1:0] shift-phase select, latched on accepted start
//   count     in   [CNT_W-1:0] shift-phase cycle count, latched on accepted start
//   pause     in   freezes the shift phase (only with SHIFT_PAUSE_EN)
//   abort     in   synchronous cancel of a running operation
//   s0, s1    out  datapath mode selects
//   dp_reset  out  active-high datapath clear
//   busy      out  high outside IDLE
//   done      out  one-cycle completion pulse
//   step      out  [CNT_W-1:0] remaining shift-phase cycles
//
// Build option: define SHIFT_PAUSE_EN to honour the pause input; otherwise pause
// is accepted on the port but has no effect.

module shift_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic             pause,
  input  logic             abort,
  output logic             s0,
  output logic             s1,
  output logic             dp_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] step_d;
  // High while the current SHIFT cycle is a frozen (paused) cycle.
  logic             paused_q, paused_d;
  logic             pause_en;

  logic             s0_d, s1_d, dp_reset_d, busy_d, done_d;

`ifdef SHIFT_PAUSE_EN
  assign pause_en = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_en     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      step     <= '0;
      paused_q <= 1'b0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      dp_reset <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      step     <= step_d;
      paused_q <= paused_d;
      s0       <= s0_d;
      s1       <= s1_d;
      dp_reset <= dp_reset_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    step_d     = step;
    paused_d   = 1'b0;
    s0_d       = 1'b0;
    s1_d       = 1'b0;
    dp_reset_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          op_d    = op;
          step_d  = count;
        end
      end
      CLR:  state_d = LOAD;
      LOAD: state_d = (step != '0) ? SHIFT : DONE;
      SHIFT: begin
        // A paused cycle leaves step alone; the pause input at this edge
        // decides whether the following cycle is paused as well.
        if (paused_q) begin
          paused_d = pause_en;
        end else if (step != '0) begin
          step_d = step - CNT_W'(1);
          if (step == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            paused_d = pause_en;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      step_d   = '0;
      paused_d = 1'b0;
    end

    // Register the outputs of the state being entered.
    busy_d = (state_d != IDLE);
    case (state_d)
      CLR:  dp_reset_d = 1'b1;
      LOAD: begin
        s1_d = 1'b1;
        s0_d = 1'b1;
      end
      SHIFT: begin
        if (!paused_d) begin
          s1_d = op_d[1];
          s0_d = op_d[0];
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

endmodule
